// File: rtl/noc_input_vc_buffer.sv
// Per-port NoC input buffer: one circular FIFO per virtual channel with credit return,
// occupancy reporting, per-VC flush and sticky protocol-error detection.
module noc_input_vc_buffer #(
   parameter int CHANNELS  = 4,
   parameter int DEPTH     = 8,
   parameter int FLIT_W    = 64,
   parameter int THRESHOLD = DEPTH - 2,
   parameter bit SHARED_IN = 1'b1
) (
   input  logic                                          noc_clk,
   input  logic                                          noc_rst,
   input  logic [CHANNELS-1:0]                           in_valid,
   input  logic [(SHARED_IN ? FLIT_W : CHANNELS*FLIT_W)-1:0] in_flit,
   output logic [CHANNELS-1:0]                           in_ready,
   output logic [CHANNELS-1:0]                           in_vc_ready,
   output logic [CHANNELS-1:0]                           credit_out,
   input  logic [CHANNELS-1:0]                           i_clear,
   output logic [CHANNELS-1:0]                           out_valid,
   output logic [CHANNELS*FLIT_W-1:0]                    out_flit,
   input  logic [CHANNELS-1:0]                           out_ready,
   output logic [CHANNELS*$clog2(DEPTH+1)-1:0]           o_occupancy,
   output logic                                          o_proto_err
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam int OCC_W  = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]    wr_ptr [CHANNELS];
   logic [PTR_W-1:0]    rd_ptr [CHANNELS];
   logic [PTR_W-1:0]    count  [CHANNELS];
   logic [FLIT_W-1:0]   mem    [CHANNELS][DEPTH];
   logic [FLIT_W-1:0]   wdata  [CHANNELS];
   logic [CHANNELS-1:0] full;
   logic [CHANNELS-1:0] empty;
   logic [CHANNELS-1:0] push;
   logic [CHANNELS-1:0] pop;
   logic [CHANNELS-1:0] vc_ready_q;
   logic                taken;
   logic                multi_valid;
   logic                ignored_bp;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
      if (SHARED_IN) begin : g_shared
         assign wdata[i] = in_flit[FLIT_W-1:0];
      end else begin : g_ext
         assign wdata[i] = in_flit[i*FLIT_W +: FLIT_W];
      end

      // Pointers carry one extra wrap bit so full and empty are distinguishable.
      assign count[i]       = wr_ptr[i] - rd_ptr[i];
      assign full[i]        = (wr_ptr[i][ADDR_W] != rd_ptr[i][ADDR_W]) &&
                              (wr_ptr[i][ADDR_W-1:0] == rd_ptr[i][ADDR_W-1:0]);
      assign empty[i]       = (wr_ptr[i] == rd_ptr[i]);
      assign in_ready[i]    = !full[i] && !i_clear[i];
      assign in_vc_ready[i] = {{(32-PTR_W){1'b0}}, count[i]} < 32'(THRESHOLD);
      assign out_valid[i]   = !empty[i];
      assign out_flit[i*FLIT_W +: FLIT_W]    = mem[i][rd_ptr[i][ADDR_W-1:0]];
      assign o_occupancy[i*OCC_W +: OCC_W]   = OCC_W'(count[i]);
      assign pop[i]         = out_valid[i] && out_ready[i];
   end

   // On a shared bus only the lowest-index requesting VC that can accept is written.
   always_comb begin
      push  = '0;
      taken = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (in_valid[i] && in_ready[i] && !taken) begin
            push[i] = 1'b1;
            taken   = SHARED_IN;
         end
      end
   end

   assign multi_valid = SHARED_IN && ($countones(in_valid) > 1);
   assign ignored_bp  = |(in_valid & ~in_ready & ~vc_ready_q);

   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
         credit_out  <= '0;
         vc_ready_q  <= '1;
         o_proto_err <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (i_clear[i]) begin
               wr_ptr[i] <= '0;
               rd_ptr[i] <= '0;
            end else begin
               if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
               if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
         end
         // A pop coinciding with a flush still returns its credit.
         credit_out <= pop;
         vc_ready_q <= in_vc_ready;
         if (multi_valid || ignored_bp) o_proto_err <= 1'b1;
      end
   end

   always_ff @(posedge noc_clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (push[i]) mem[i][wr_ptr[i][ADDR_W-1:0]] <= wdata[i];
      end
   end

endmodule
